// File: rtl/flux_burst_scheduler.sv
// Round-robin burst scheduler: grants one source flux at a time and forwards
// BURST tokens from it into a shared sink, tagging each token with its flux id.
module flux_burst_scheduler #(
    parameter int unsigned FLUX       = 2,
    parameter int unsigned DATA_WIDTH = 7,
    parameter int unsigned BURST      = 8,
    parameter int unsigned TAG_WIDTH  = $clog2(FLUX)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sched_en,
    input  logic [FLUX-1:0]               in_empty,
    input  logic [FLUX*DATA_WIDTH-1:0]    in_dout,
    output logic [FLUX-1:0]               in_read,
    input  logic                          out_full,
    output logic                          out_write,
    output logic [TAG_WIDTH+DATA_WIDTH-1:0] out_din,
    output logic                          busy,
    output logic [TAG_WIDTH-1:0]          grant_tag
);

    localparam int unsigned CntWidth = $clog2(BURST + 1);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    state_e                state_q, state_d;
    logic [CntWidth-1:0]   cnt_q, cnt_d;
    logic [TAG_WIDTH-1:0]  grant_q, grant_d;
    logic [TAG_WIDTH-1:0]  rr_q, rr_d;

    logic                  sel_found;
    logic [TAG_WIDTH-1:0]  sel_tag;
    logic [TAG_WIDTH-1:0]  idx;
    logic                  fire;
    logic                  last_tok;

    // Pick the first non-empty flux starting at rr_q, wrapping modulo FLUX.
    always_comb begin
        sel_found = 1'b0;
        sel_tag   = '0;
        idx       = '0;
        for (int unsigned k = 0; k < FLUX; k++) begin
            idx = TAG_WIDTH'((32'(rr_q) + k) % FLUX);
            if (!sel_found && !in_empty[idx]) begin
                sel_found = 1'b1;
                sel_tag   = idx;
            end
        end
    end

    // Transfer datapath: a token moves only when the granted source has data
    // and the sink has room; reset blocks any transfer in the same cycle.
    always_comb begin
        fire      = !rst && (state_q == StGrant) && !in_empty[grant_q] && !out_full;
        last_tok  = (32'(cnt_q) == BURST - 1);
        in_read   = '0;
        out_write = 1'b0;
        out_din   = '0;
        if (fire) begin
            in_read   = FLUX'(1) << grant_q;
            out_write = 1'b1;
            out_din   = {grant_q, in_dout[grant_q*DATA_WIDTH +: DATA_WIDTH]};
        end
    end

    // Next-state logic: bubble in IDLE, count tokens in GRANT, stall holds all.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        unique case (state_q)
            StIdle: begin
                if (sched_en && sel_found) begin
                    state_d = StGrant;
                    grant_d = sel_tag;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (fire) begin
                    if (last_tok) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                        rr_d    = (32'(grant_q) == FLUX - 1) ? '0 : grant_q + 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            grant_q <= '0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
        end
    end

    assign busy      = (state_q == StGrant);
    assign grant_tag = grant_q;

endmodule

// File: tb/tb_flux_burst_scheduler.sv
// Directed bench: a FLUX=2/BURST=4 instance driven from a vector table, and a
// FLUX=3/BURST=2 instance driven by a hand-written wrap/reset sequence.
module tb_flux_burst_scheduler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // FLUX=2, BURST=4, DATA_WIDTH=7 instance
    logic        rst2, en2, full2, wr2, busy2, tag2;
    logic [1:0]  empty2, rd2;
    logic [13:0] dout2;
    logic [7:0]  din2;

    flux_burst_scheduler #(.FLUX(2), .DATA_WIDTH(7), .BURST(4)) dut2 (
        .clk       (clk),
        .rst       (rst2),
        .sched_en  (en2),
        .in_empty  (empty2),
        .in_dout   (dout2),
        .in_read   (rd2),
        .out_full  (full2),
        .out_write (wr2),
        .out_din   (din2),
        .busy      (busy2),
        .grant_tag (tag2)
    );

    // FLUX=3, BURST=2, DATA_WIDTH=7 instance
    logic        rst3, en3, full3, wr3, busy3;
    logic [2:0]  empty3, rd3;
    logic [20:0] dout3;
    logic [8:0]  din3;
    logic [1:0]  tag3;

    flux_burst_scheduler #(.FLUX(3), .DATA_WIDTH(7), .BURST(2)) dut3 (
        .clk       (clk),
        .rst       (rst3),
        .sched_en  (en3),
        .in_empty  (empty3),
        .in_dout   (dout3),
        .in_read   (rd3),
        .out_full  (full3),
        .out_write (wr3),
        .out_din   (din3),
        .busy      (busy3),
        .grant_tag (tag3)
    );

    typedef struct {
        logic       rst;
        logic       en;
        logic [1:0] empty;
        logic       full;
        logic [6:0] d0;
        logic [6:0] d1;
        logic [1:0] rd;
        logic       wr;
        logic [7:0] din;
        logic       busy;
        logic       tag;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic en, input logic [1:0] e, input logic f,
                       input logic [6:0] d0, input logic [6:0] d1, input logic [1:0] rd,
                       input logic wr, input logic [7:0] din, input logic b, input logic t);
        vec_t v;
        v.rst = r; v.en = en; v.empty = e; v.full = f; v.d0 = d0; v.d1 = d1;
        v.rd = rd; v.wr = wr; v.din = din; v.busy = b; v.tag = t;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset two cycles with data present, then sched_en low: nothing moves.
        add(1, 1, 2'b00, 0, 7'h11, 7'h21, 2'b00, 0, 8'h00, 0, 0);
        add(1, 1, 2'b00, 0, 7'h11, 7'h21, 2'b00, 0, 8'h00, 0, 0);
        add(0, 0, 2'b00, 0, 7'h11, 7'h21, 2'b00, 0, 8'h00, 0, 0);
        add(0, 0, 2'b00, 0, 7'h11, 7'h21, 2'b00, 0, 8'h00, 0, 0);
        // Enable: one bubble, then four tokens from flux0.
        add(0, 1, 2'b00, 0, 7'h11, 7'h21, 2'b00, 0, 8'h00, 0, 0);
        add(0, 1, 2'b00, 0, 7'h11, 7'h21, 2'b01, 1, 8'h11, 1, 0);
        add(0, 1, 2'b00, 0, 7'h12, 7'h21, 2'b01, 1, 8'h12, 1, 0);
        add(0, 1, 2'b00, 0, 7'h13, 7'h21, 2'b01, 1, 8'h13, 1, 0);
        add(0, 1, 2'b00, 0, 7'h14, 7'h21, 2'b01, 1, 8'h14, 1, 0);
        // Bubble, then four tokens from flux1 tagged 1.
        add(0, 1, 2'b00, 0, 7'h15, 7'h21, 2'b00, 0, 8'h00, 0, 0);
        add(0, 1, 2'b00, 0, 7'h15, 7'h21, 2'b10, 1, 8'hA1, 1, 1);
        add(0, 1, 2'b00, 0, 7'h15, 7'h22, 2'b10, 1, 8'hA2, 1, 1);
        add(0, 1, 2'b00, 0, 7'h15, 7'h23, 2'b10, 1, 8'hA3, 1, 1);
        add(0, 1, 2'b00, 0, 7'h15, 7'h24, 2'b10, 1, 8'hA4, 1, 1);
        // Bubble (tag holds 1), rr wraps to flux0; sink full after 2nd token.
        add(0, 1, 2'b00, 0, 7'h15, 7'h25, 2'b00, 0, 8'h00, 0, 1);
        add(0, 1, 2'b00, 0, 7'h15, 7'h25, 2'b01, 1, 8'h15, 1, 0);
        add(0, 1, 2'b00, 0, 7'h16, 7'h25, 2'b01, 1, 8'h16, 1, 0);
        add(0, 1, 2'b00, 1, 7'h17, 7'h25, 2'b00, 0, 8'h00, 1, 0);
        add(0, 1, 2'b00, 1, 7'h17, 7'h25, 2'b00, 0, 8'h00, 1, 0);
        add(0, 1, 2'b00, 1, 7'h17, 7'h25, 2'b00, 0, 8'h00, 1, 0);
        add(0, 1, 2'b00, 0, 7'h17, 7'h25, 2'b01, 1, 8'h17, 1, 0);
        add(0, 1, 2'b00, 0, 7'h18, 7'h25, 2'b01, 1, 8'h18, 1, 0);
        // rr=1 but flux1 empty: scan skips to flux0.
        add(0, 1, 2'b10, 0, 7'h19, 7'h25, 2'b00, 0, 8'h00, 0, 0);
        add(0, 1, 2'b00, 0, 7'h19, 7'h25, 2'b01, 1, 8'h19, 1, 0);
        add(0, 1, 2'b00, 0, 7'h1A, 7'h25, 2'b01, 1, 8'h1A, 1, 0);
        // flux0 runs dry mid-burst: flux1 must not be touched.
        add(0, 1, 2'b01, 0, 7'h1B, 7'h25, 2'b00, 0, 8'h00, 1, 0);
        add(0, 1, 2'b01, 0, 7'h1B, 7'h25, 2'b00, 0, 8'h00, 1, 0);
        add(0, 1, 2'b00, 0, 7'h1B, 7'h25, 2'b01, 1, 8'h1B, 1, 0);
        add(0, 1, 2'b00, 0, 7'h1C, 7'h25, 2'b01, 1, 8'h1C, 1, 0);
        // Bubble, flux1 granted; sched_en dropped after first token.
        add(0, 1, 2'b00, 0, 7'h1D, 7'h25, 2'b00, 0, 8'h00, 0, 0);
        add(0, 1, 2'b00, 0, 7'h1D, 7'h25, 2'b10, 1, 8'hA5, 1, 1);
        add(0, 0, 2'b00, 0, 7'h1D, 7'h26, 2'b10, 1, 8'hA6, 1, 1);
        add(0, 0, 2'b00, 0, 7'h1D, 7'h27, 2'b10, 1, 8'hA7, 1, 1);
        add(0, 0, 2'b00, 0, 7'h1D, 7'h28, 2'b10, 1, 8'hA8, 1, 1);
        add(0, 0, 2'b00, 0, 7'h1D, 7'h29, 2'b00, 0, 8'h00, 0, 1);
        add(0, 0, 2'b00, 0, 7'h1D, 7'h29, 2'b00, 0, 8'h00, 0, 1);
        add(0, 0, 2'b00, 0, 7'h1D, 7'h29, 2'b00, 0, 8'h00, 0, 1);

        rst2 = 1'b1; en2 = 1'b1; empty2 = 2'b00; full2 = 1'b0; dout2 = '0;
        rst3 = 1'b1; en3 = 1'b1; empty3 = 3'b011; full3 = 1'b0;
        dout3 = {7'h32, 7'h22, 7'h12};
        step();

        for (int i = 0; i < vecs.size(); i++) begin
            rst2   = vecs[i].rst;
            en2    = vecs[i].en;
            empty2 = vecs[i].empty;
            full2  = vecs[i].full;
            dout2  = {vecs[i].d1, vecs[i].d0};
            #1;
            chk($sformatf("v%0d in_read", i),   32'(rd2),   32'(vecs[i].rd));
            chk($sformatf("v%0d out_write", i), 32'(wr2),   32'(vecs[i].wr));
            chk($sformatf("v%0d out_din", i),   32'(din2),  32'(vecs[i].din));
            chk($sformatf("v%0d busy", i),      32'(busy2), 32'(vecs[i].busy));
            chk($sformatf("v%0d grant_tag", i), 32'(tag2),  32'(vecs[i].tag));
            step();
        end

        // FLUX=3: only flux2 has data, then all do -> grant order 2,0,1,2.
        rst3 = 1'b0;
        #1;
        chk("f3 idle busy", 32'(busy3), 32'd0);
        chk("f3 idle read", 32'(rd3), 32'd0);
        step();
        chk("f3 first grant", 32'(tag3), 32'd2);
        chk("f3 first busy", 32'(busy3), 32'd1);
        empty3 = 3'b000;
        #1;
        chk("f3 g2 read", 32'(rd3), 32'b100);
        chk("f3 g2 din", 32'(din3), 32'h132);
        step();
        chk("f3 g2 read2", 32'(rd3), 32'b100);
        step();
        chk("f3 bubble busy", 32'(busy3), 32'd0);
        chk("f3 bubble write", 32'(wr3), 32'd0);
        step();
        chk("f3 wrap grant", 32'(tag3), 32'd0);
        chk("f3 g0 read", 32'(rd3), 32'b001);
        chk("f3 g0 din", 32'(din3), 32'h012);
        step();
        step();
        step();
        chk("f3 third grant", 32'(tag3), 32'd1);
        chk("f3 g1 din", 32'(din3), 32'h0A2);
        step();
        step();
        step();
        chk("f3 fourth grant", 32'(tag3), 32'd2);
        chk("f3 g2b read", 32'(rd3), 32'b100);
        step();
        // Reset mid-burst: outputs forced off, burst abandoned.
        rst3 = 1'b1;
        #1;
        chk("f3 rst read", 32'(rd3), 32'd0);
        chk("f3 rst write", 32'(wr3), 32'd0);
        chk("f3 rst din", 32'(din3), 32'd0);
        step();
        rst3 = 1'b0;
        #1;
        chk("f3 post-rst busy", 32'(busy3), 32'd0);
        chk("f3 post-rst tag", 32'(tag3), 32'd0);
        step();
        chk("f3 post-rst grant", 32'(tag3), 32'd0);
        chk("f3 post-rst read", 32'(rd3), 32'b001);
        step();
        chk("f3 cnt restart busy", 32'(busy3), 32'd1);
        chk("f3 cnt restart read", 32'(rd3), 32'b001);
        step();
        chk("f3 burst done", 32'(busy3), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
